// File: rtl/aes_sbox_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aes_sbox_arbiter
// Purpose  : Shares one combinational AES S-box between N_REQ requesters
//            (e.g. SubBytes and key expansion). Grants are registered,
//            exclusive and last while the owner's request stays high.
//            Hand-over to the next winner happens on the release edge with
//            no idle bubble. Burst length is counted and overruns latched.
// Config   : ARB_RR_EN defined   -> round-robin from last_winner+1
//            ARB_RR_EN undefined -> fixed priority, lowest index first
// Ports    : clk, reset        clock / synchronous active-high reset
//            req_i[N]          per-requester request (held for the burst)
//            decrypt_i[N]      per-requester inverse-S-box select
//            data_i[8N]        per-requester byte, requester k at [8k+7:8k]
//            grant_o[N]        registered one-hot grant
//            busy_o            registered, high while a grant is active
//            owner_o[2]        registered owner index (0 when idle)
//            data_o[8]         S-box result broadcast (valid for owner)
//            sbox_data_o[8]    byte to shared S-box
//            sbox_decrypt_o    inverse select to shared S-box
//            sbox_data_i[8]    shared S-box result
//            overrun_o         sticky burst-overrun flag
//            burst_cnt_o[5]    granted cycles in current burst (sat. 31)
// Revision : 1.0  initial release
// ============================================================================
module aes_sbox_arbiter #(
  parameter int N_REQ     = 2,
  parameter int MAX_BURST = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ-1:0]   decrypt_i,
  input  logic [8*N_REQ-1:0] data_i,
  output logic [N_REQ-1:0]   grant_o,
  output logic               busy_o,
  output logic [1:0]         owner_o,
  output logic [7:0]         data_o,
  output logic [7:0]         sbox_data_o,
  output logic               sbox_decrypt_o,
  input  logic [7:0]         sbox_data_i,
  output logic               overrun_o,
  output logic [4:0]         burst_cnt_o
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_OWN  = 1'b1
  } state_t;

  localparam logic [4:0] c_CNT_SAT = 5'd31;

  state_t             r_state, w_state_nxt;
  logic [N_REQ-1:0]   r_grant, w_grant_nxt;
  logic [1:0]         r_owner, w_owner_nxt;
  logic [4:0]         r_cnt, w_cnt_nxt;
  logic               r_overrun, w_overrun_nxt;
  logic               w_owner_req;
  logic               w_arb;
  logic               w_found;
  logic [1:0]         w_winner;

  // --------------------------------------------------------------------------
  // Winner selection
  // --------------------------------------------------------------------------
`ifdef ARB_RR_EN
  logic [1:0] r_last, w_last_nxt;
  logic [2:0] w_idx;

  // Search upward from last_winner+1 with wrap. last+1+i never exceeds
  // 2*N_REQ-1, so a single conditional subtraction implements the modulo.
  always_comb begin
    w_found  = 1'b0;
    w_winner = 2'd0;
    w_idx    = 3'd0;
    for (int i = 0; i < N_REQ; i++) begin
      w_idx = {1'b0, r_last} + 3'd1 + 3'(i);
      if (w_idx >= 3'(N_REQ)) w_idx = w_idx - 3'(N_REQ);
      for (int k = 0; k < N_REQ; k++) begin
        if (!w_found && req_i[k] && (w_idx == 3'(k))) begin
          w_found  = 1'b1;
          w_winner = 2'(k);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_last <= 2'(N_REQ - 1);
    else       r_last <= w_last_nxt;
  end
`else
  always_comb begin
    w_found  = 1'b0;
    w_winner = 2'd0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && req_i[k]) begin
        w_found  = 1'b1;
        w_winner = 2'(k);
      end
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Owner-indexed muxes (request, lookup byte, inverse select)
  // --------------------------------------------------------------------------
  always_comb begin
    w_owner_req    = 1'b0;
    sbox_data_o    = 8'h00;
    sbox_decrypt_o = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_owner == 2'(k)) begin
        w_owner_req = req_i[k];
        if (r_state == S_OWN) begin
          sbox_data_o    = data_i[8*k +: 8];
          sbox_decrypt_o = decrypt_i[k];
        end
      end
    end
  end

  assign data_o = sbox_data_i;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  // Arbitration only happens while idle or on the owner's release edge, so
  // the owner is never preempted.
  assign w_arb = (r_state == S_IDLE) || !w_owner_req;

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
`ifdef ARB_RR_EN
    w_last_nxt  = r_last;
`endif
    if (w_arb) begin
      if (w_found) begin
        w_state_nxt = S_OWN;
        w_owner_nxt = w_winner;
        w_cnt_nxt   = 5'd1;
        w_grant_nxt = '0;
        for (int k = 0; k < N_REQ; k++) begin
          w_grant_nxt[k] = (w_winner == 2'(k));
        end
`ifdef ARB_RR_EN
        w_last_nxt  = w_winner;
`endif
      end else begin
        w_state_nxt = S_IDLE;
        w_owner_nxt = 2'd0;
        w_cnt_nxt   = 5'd0;
        w_grant_nxt = '0;
      end
    end else if (r_cnt != c_CNT_SAT) begin
      w_cnt_nxt = r_cnt + 5'd1;
    end
    w_overrun_nxt = r_overrun | ({27'd0, w_cnt_nxt} > MAX_BURST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_owner   <= 2'd0;
      r_cnt     <= 5'd0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_owner   <= w_owner_nxt;
      r_cnt     <= w_cnt_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  assign grant_o     = r_grant;
  assign busy_o      = (r_state == S_OWN);
  assign owner_o     = r_owner;
  assign burst_cnt_o = r_cnt;
  assign overrun_o   = r_overrun;

endmodule
`default_nettype wire
